// File: rtl/vscale_mul_div_arbiter.sv
// Shares one multi-cycle mul/div unit between two requesters. Only one transaction
// is outstanding at a time; grants are round-robin, and a watchdog bounds the wait.
`ifndef XPR_LEN
`define XPR_LEN 32
`endif
`ifndef MUL_DIV_OP_WIDTH
`define MUL_DIV_OP_WIDTH 2
`endif

module vscale_mul_div_arbiter #(
    parameter int MAX_LAT = 64
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         req0_valid,
    output logic                         req0_ready,
    input  logic [`MUL_DIV_OP_WIDTH-1:0] req0_op,
    input  logic [`XPR_LEN-1:0]          req0_in_1,
    input  logic [`XPR_LEN-1:0]          req0_in_2,
    input  logic                         req0_kill,
    output logic                         resp0_valid,
    output logic [`XPR_LEN-1:0]          resp0_out,
    output logic                         resp0_err,
    input  logic                         req1_valid,
    output logic                         req1_ready,
    input  logic [`MUL_DIV_OP_WIDTH-1:0] req1_op,
    input  logic [`XPR_LEN-1:0]          req1_in_1,
    input  logic [`XPR_LEN-1:0]          req1_in_2,
    input  logic                         req1_kill,
    output logic                         resp1_valid,
    output logic [`XPR_LEN-1:0]          resp1_out,
    output logic                         resp1_err,
    output logic                         md_req_valid,
    output logic [`MUL_DIV_OP_WIDTH-1:0] md_req_op,
    output logic [`XPR_LEN-1:0]          md_req_in_1,
    output logic [`XPR_LEN-1:0]          md_req_in_2,
    input  logic                         md_resp_valid,
    input  logic [`XPR_LEN-1:0]          md_resp_out
);
    localparam int W   = `XPR_LEN;
    localparam int OPW = `MUL_DIV_OP_WIDTH;
    // Counter starts at 0 on WAIT entry; the last WAIT cycle is the one where it would reach MAX_LAT-1.
    localparam logic [7:0] WD_LAST = 8'(MAX_LAT - 2);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } state_t;

    state_t           state_reg;
    logic             prio_reg;
    logic             owner_reg;
    logic             killed_reg;
    logic [7:0]       wd_cnt_reg;
    logic             md_req_valid_reg;
    logic [OPW-1:0]   md_req_op_reg;
    logic [W-1:0]     md_req_in_1_reg;
    logic [W-1:0]     md_req_in_2_reg;

    logic [1:0]       req_valid;
    logic [1:0]       req_kill;
    logic [1:0]       grant;
    logic [OPW-1:0]   req_op   [2];
    logic [W-1:0]     req_in_1 [2];
    logic [W-1:0]     req_in_2 [2];

    logic             is_idle;
    logic             kill_now;
    logic             killed_eff;
    logic             resp_hit;
    logic             timeout;
    logic             deliver;

    assign req_valid   = {req1_valid, req0_valid};
    assign req_kill    = {req1_kill, req0_kill};
    assign req_op[0]   = req0_op;
    assign req_op[1]   = req1_op;
    assign req_in_1[0] = req0_in_1;
    assign req_in_1[1] = req1_in_1;
    assign req_in_2[0] = req0_in_2;
    assign req_in_2[1] = req1_in_2;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_grant
            // A lone requester always wins; on contention prio picks the winner.
            assign grant[gi] = req_valid[gi] & (~req_valid[1-gi] | (prio_reg == 1'(gi)));
        end
    endgenerate

    assign is_idle    = (state_reg == IDLE);
    assign req0_ready = reset & is_idle & grant[0];
    assign req1_ready = reset & is_idle & grant[1];

    // A kill landing in the completion cycle itself must still suppress the pulse.
    assign kill_now   = (state_reg != IDLE) & req_kill[owner_reg];
    assign killed_eff = killed_reg | kill_now;
    assign resp_hit   = (state_reg == WAIT) & md_resp_valid;
    assign timeout    = (state_reg == WAIT) & ~md_resp_valid & (wd_cnt_reg == WD_LAST);
    assign deliver    = (resp_hit | timeout) & ~killed_eff;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg        <= IDLE;
            prio_reg         <= 1'b0;
            owner_reg        <= 1'b0;
            killed_reg       <= 1'b0;
            wd_cnt_reg       <= '0;
            md_req_valid_reg <= 1'b0;
            md_req_op_reg    <= '0;
            md_req_in_1_reg  <= '0;
            md_req_in_2_reg  <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (|grant) begin
                        state_reg        <= ISSUE;
                        owner_reg        <= grant[1];
                        prio_reg         <= grant[0];
                        killed_reg       <= 1'b0;
                        md_req_valid_reg <= 1'b1;
                        md_req_op_reg    <= req_op[grant[1]];
                        md_req_in_1_reg  <= req_in_1[grant[1]];
                        md_req_in_2_reg  <= req_in_2[grant[1]];
                    end
                end
                ISSUE: begin
                    state_reg        <= WAIT;
                    md_req_valid_reg <= 1'b0;
                    wd_cnt_reg       <= '0;
                    if (kill_now) begin
                        killed_reg <= 1'b1;
                    end
                end
                WAIT: begin
                    if (kill_now) begin
                        killed_reg <= 1'b1;
                    end
                    if (resp_hit || timeout) begin
                        state_reg <= IDLE;
                    end else begin
                        wd_cnt_reg <= wd_cnt_reg + 8'd1;
                    end
                end
                default: begin
                    state_reg        <= IDLE;
                    md_req_valid_reg <= 1'b0;
                end
            endcase
        end
    end

    assign md_req_valid = md_req_valid_reg;
    assign md_req_op    = md_req_op_reg;
    assign md_req_in_1  = md_req_in_1_reg;
    assign md_req_in_2  = md_req_in_2_reg;

    generate
        for (gi = 0; gi < 2; gi++) begin : g_resp
            logic         valid_reg;
            logic         err_reg;
            logic [W-1:0] out_reg;
            logic         mine;

            assign mine = deliver & (owner_reg == 1'(gi));

            // Result and error flag persist until the next pulse for this requester.
            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    valid_reg <= 1'b0;
                    err_reg   <= 1'b0;
                    out_reg   <= '0;
                end else begin
                    valid_reg <= mine;
                    if (mine) begin
                        out_reg <= resp_hit ? md_resp_out : '0;
                        err_reg <= ~resp_hit;
                    end
                end
            end
        end
    endgenerate

    assign resp0_valid = g_resp[0].valid_reg;
    assign resp0_out   = g_resp[0].out_reg;
    assign resp0_err   = g_resp[0].err_reg;
    assign resp1_valid = g_resp[1].valid_reg;
    assign resp1_out   = g_resp[1].out_reg;
    assign resp1_err   = g_resp[1].err_reg;

endmodule
